mips_cpu_muldiv_unit: RTL and testbench

- Multi-cycle, parametrised multiply/divide engine that owns the HI/LO register pair for the harvard/bus CPU cores.
- Replaces the combinational `*`, `/` and `%` datapath with a synthesisable iterative unit: one shift-add or restoring-divide step per cycle.
- Adds busy/done handshaking, flush/cancel and fully defined divide-by-zero and overflow results.
- Sits beside the ALU. The CPU issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here and must stall MFHI/MFLO while busy=1.

---
 rtl/mips_cpu_muldiv_unit.sv | 132 +++++++++++++
 tb/tb_mips_cpu_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv_unit.sv
// Purpose: iterative MIPS multiply/divide engine that owns the HI/LO register pair.
// Latency: MULT/DIV-class results land WIDTH+2 enabled edges after issue; MTHI/MTLO land in one edge.
// Backpressure: busy is high while an operation is in flight; starts seen while busy are dropped.
module mips_cpu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t               state;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc;
    // Multiplicand or divisor magnitude.
    logic [WIDTH-1:0]     opnd;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 neg_q;     // negate product (MULT) or quotient (DIV)
    logic                 neg_r;     // negate remainder (DIV: dividend was negative)
    logic                 div_zero;

    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;

    assign busy = (state != IDLE);

    // Operand magnitudes plus one shift-add / restoring-divide step and the sign-fixed results.
    always_comb begin
        a_abs    = a[WIDTH-1] ? -a : a;
        b_abs    = b[WIDTH-1] ? -b : b;

        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

        // Remainder is always below the divisor, so bit WIDTH of the trial is a true borrow.
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod     = neg_q ? -acc : acc;
        quo      = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];

        fix_hi   = prod[2*WIDTH-1:WIDTH];
        fix_lo   = prod[WIDTH-1:0];
        if (is_div) begin
            // Divide by zero leaves remainder = |dividend|, so re-signing it yields a.
            fix_hi = neg_r ? -rem : rem;
            fix_lo = div_zero ? '1 : (neg_q ? -quo : quo);
        end
    end

    // Control FSM and datapath registers; everything holds when clk_enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (clk_enable) begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                3'd0, 3'd1, 3'd2, 3'd3: begin
                                    cnt      <= CNT_W'(WIDTH - 1);
                                    state    <= CALC;
                                    is_div   <= op[1];
                                    div_zero <= op[1] && (b == '0);
                                    neg_q    <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r    <= (op == 3'd2) && a[WIDTH-1];
                                    if (op[1]) begin
                                        acc  <= {{WIDTH{1'b0}}, op[0] ? a : a_abs};
                                        opnd <= op[0] ? b : b_abs;
                                    end else begin
                                        acc  <= {{WIDTH{1'b0}}, op[0] ? b : b_abs};
                                        opnd <= op[0] ? a : a_abs;
                                    end
                                end
                                3'd4:    hi <= a;
                                3'd5:    lo <= a;
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_next : mul_next;
                        if (cnt == '0)
                            state <= FIXUP;
                        else
                            cnt <= cnt - CNT_W'(1);
                    end
                    FIXUP: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
module tb_mips_cpu_muldiv_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset, clk_enable, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] m_hi, m_lo;

    mips_cpu_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Architectural reference: what HI/LO hold after the instruction retires.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W-1:0] sx, sy;
        longint              sp;
        logic [2*W-1:0]      up;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin sp = longint'(sx) * longint'(sy); {m_hi, m_lo} = sp; end
            3'd1: begin up = {{W{1'b0}}, x} * {{W{1'b0}}, y}; {m_hi, m_lo} = up; end
            3'd2: begin
                if (y == '0)                   begin m_hi = x; m_lo = '1; end
                else if (x == MIN && y == '1)  begin m_hi = '0; m_lo = MIN; end
                else                           begin m_lo = sx / sy; m_hi = sx % sy; end
            end
            3'd3: begin
                if (y == '0) begin m_hi = x; m_lo = '1; end
                else         begin m_lo = x / y; m_hi = x % y; end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Issue a MULT/DIV-class op, optionally stalling or injecting a start while busy.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int stall_at, input int stall_len, input int intr_at);
        int n, nbusy;
        bit seen;
        op = o; a = x; b = y; start = 1'b1;
        step;
        start = 1'b0; a = $urandom; b = $urandom;
        model(o, x, y);
        nbusy = busy ? 1 : 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            clk_enable = !(n >= stall_at && n < stall_at + stall_len);
            if (n == intr_at) begin
                start = 1'b1; op = 3'd3; a = $urandom; b = $urandom_range(1, 9);
            end else begin
                start = 1'b0;
            end
            step;
            n++;
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        clk_enable = 1'b1;
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(n), 64'(W + 1 + stall_len));
        chk("busy_cycles", 64'(nbusy), 64'(W + 1 + stall_len));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
        step;
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    // MTHI/MTLO and reserved ops: single-edge, never busy, never done.
    task automatic run_move(input logic [2:0] o, input logic [W-1:0] x);
        op = o; a = x; b = $urandom; start = 1'b1;
        step;
        start = 1'b0;
        model(o, x, '0);
        chk("mv_hi", 64'(hi), 64'(m_hi));
        chk("mv_lo", 64'(lo), 64'(m_lo));
        chk("mv_busy", 64'(busy), 64'd0);
        chk("mv_done", 64'(done), 64'd0);
    endtask

    initial begin
        int sel;
        bit done_seen;
        logic [2:0]   o;
        logic [W-1:0] x, y;

        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        step; step;
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, -1);
        chk("tp_multu_hi", 64'(hi), 64'h0FFFFFFFE);
        chk("tp_multu_lo", 64'(lo), 64'h000000001);
        run_op(3'd0, 32'hFFFFFFFD, 32'h00000007, -1, 0, -1);
        chk("tp_mult_hi", 64'(hi), 64'h0FFFFFFFF);
        chk("tp_mult_lo", 64'(lo), 64'h0FFFFFFEB);
        run_op(3'd0, 32'd7, 32'd7, -1, 0, -1);
        chk("tp_mult7_lo", 64'(lo), 64'h31);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, -1, 0, -1);
        chk("tp_div_lo", 64'(lo), 64'h0FFFFFFFD);
        chk("tp_div_hi", 64'(hi), 64'h0FFFFFFFF);
        run_op(3'd3, 32'd7, 32'd2, -1, 0, -1);
        chk("tp_divu_lo", 64'(lo), 64'd3);
        chk("tp_divu_hi", 64'(hi), 64'd1);
        run_op(3'd2, MIN, 32'hFFFFFFFF, -1, 0, -1);
        chk("tp_ovf_lo", 64'(lo), 64'h080000000);
        chk("tp_ovf_hi", 64'(hi), 64'd0);
        run_op(3'd3, 32'd5, 32'd0, -1, 0, -1);
        chk("tp_divu0_lo", 64'(lo), 64'h0FFFFFFFF);
        chk("tp_divu0_hi", 64'(hi), 64'd5);
        run_op(3'd2, 32'hFFFFFFF9, 32'd0, -1, 0, -1);
        chk("tp_div0_lo", 64'(lo), 64'h0FFFFFFFF);
        chk("tp_div0_hi", 64'(hi), 64'h0FFFFFFF9);

        run_move(3'd4, 32'h12345678);
        chk("tp_mthi", 64'(hi), 64'h12345678);

        // Second start while busy must be dropped.
        run_op(3'd1, 32'h00010003, 32'h00000101, -1, 0, 5);

        // Stall mid-MULT.
        run_op(3'd0, 32'hFFFF1234, 32'h00ABCDEF, 10, 5, -1);

        // Flush ten cycles into a DIV: no result, HI/LO untouched.
        op = 3'd2; a = 32'h00001000; b = 32'd3; start = 1'b1;
        step;
        start = 1'b0;
        repeat (9) step;
        flush = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        step;
        flush = 1'b0; start = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_hi", 64'(hi), 64'(m_hi));
        chk("flush_lo", 64'(lo), 64'(m_lo));
        done_seen = 1'b0;
        repeat (40) begin
            step;
            if (done) done_seen = 1'b1;
        end
        chk("flush_no_done", 64'(done_seen), 64'd0);

        // Reset mid-DIV.
        op = 3'd2; a = 32'h7FFF0000; b = 32'd9; start = 1'b1;
        step;
        start = 1'b0;
        repeat (7) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("mrst_hi", 64'(hi), 64'd0);
        chk("mrst_lo", 64'(lo), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);

        // Randomized mix against the reference model.
        for (int i = 0; i < 40; i++) begin
            o   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            x   = $urandom;
            y   = $urandom;
            case (sel)
                0: y = '0;
                1: begin x = MIN; y = '1; end
                2: begin x = 32'($urandom_range(0, 300)) - 32'd150; y = 32'($urandom_range(1, 20)); end
                default: ;
            endcase
            if (o <= 3'd3) run_op(o, x, y, -1, 0, -1);
            else           run_move(o, x);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
